// File: rtl/jzjpcc_pkg.sv
// Shared types for the jzjpcc stage tag pipeline.
// Defines the per-stage tag bundles and their bubble encodings.
package jzjpcc_pkg;

    // Tag carried from decode into execute; rs1/rs2 are needed there for
    // hazard/bypass matching.
    typedef struct packed {
        logic       valid;
        logic [4:0] rs1Addr;
        logic [4:0] rs2Addr;
        logic [4:0] rdAddr;
        logic       rdWriteEnable;
        logic       rdSource;
    } stage_tag_t;

    // Beyond execute only the destination side of the tag is still consulted.
    typedef struct packed {
        logic       valid;
        logic [4:0] rdAddr;
        logic       rdWriteEnable;
        logic       rdSource;
    } write_tag_t;

    localparam stage_tag_t TAG_BUBBLE = '0;
    localparam write_tag_t WTAG_BUBBLE = '0;

    function automatic write_tag_t to_write_tag(stage_tag_t t);
        write_tag_t w;
        w.valid         = t.valid;
        w.rdAddr        = t.rdAddr;
        w.rdWriteEnable = t.rdWriteEnable;
        w.rdSource      = t.rdSource;
        return w;
    endfunction

endpackage

// File: rtl/jzjpcc_stage_reg.sv
// Generic pipeline register: async reset to BUBBLE, flush > stall > load.
// Ports: clock, reset, flush (load bubble), stall (hold), d, q.
module jzjpcc_stage_reg #(
    parameter type T      = logic,
    parameter T    BUBBLE = '0
) (
    input  logic clock,
    input  logic reset,
    input  logic flush,
    input  logic stall,
    input  T     d,
    output T     q
);

    T stage_q;
    T stage_d;

    always_comb begin
        stage_d = d;
        if (flush) begin
            stage_d = BUBBLE;
        end else if (stall) begin
            stage_d = stage_q;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            stage_q <= BUBBLE;
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q = stage_q;

endmodule

// File: rtl/jzjpcc_stage_tag_pipeline.sv
// Carries register-use tags and result data decode -> execute -> memory -> writeback,
// feeds the hazard unit its tags/bypass value, and counts retired instructions.
// Ports: decode tags + valid, stall_decode/flush_execute, aluResult_execute,
// loadData_memory in; execute/memory/writeback tags, aluResult_memory,
// rd_writebackEnd and retired out.
module jzjpcc_stage_tag_pipeline
    import jzjpcc_pkg::*;
#(
    parameter int XLEN         = 32,
    parameter int RETIRE_WIDTH = 64
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [4:0]              rs1Addr_decode,
    input  logic [4:0]              rs2Addr_decode,
    input  logic [4:0]              rdAddr_decode,
    input  logic                    rdWriteEnable_decode,
    input  logic                    rdSource_decode,
    input  logic                    valid_decode,
    input  logic                    stall_decode,
    input  logic                    flush_execute,
    input  logic [XLEN-1:0]         aluResult_execute,
    input  logic [XLEN-1:0]         loadData_memory,
    output logic [4:0]              rs1Addr_execute,
    output logic [4:0]              rs2Addr_execute,
    output logic [4:0]              rdAddr_execute,
    output logic                    rdWriteEnable_execute,
    output logic                    rdSource_execute,
    output logic [4:0]              rdAddr_memory,
    output logic                    rdWriteEnable_memory,
    output logic                    rdSource_memory,
    output logic [XLEN-1:0]         aluResult_memory,
    output logic [4:0]              rdAddr_writeback,
    output logic                    rdWriteEnable_writeback,
    output logic [XLEN-1:0]         rd_writebackEnd,
    output logic [RETIRE_WIDTH-1:0] retired
);

    typedef struct packed {
        write_tag_t      tag;
        logic [XLEN-1:0] alu;
    } mem_slot_t;

    typedef struct packed {
        write_tag_t      tag;
        logic [XLEN-1:0] alu;
        logic [XLEN-1:0] load;
    } wb_slot_t;

    stage_tag_t tag_decode;
    stage_tag_t tag_execute;
    mem_slot_t  mem_d;
    mem_slot_t  mem_q;
    wb_slot_t   wb_d;
    wb_slot_t   wb_q;

    logic [RETIRE_WIDTH-1:0] retired_d;
    logic [RETIRE_WIDTH-1:0] retired_q;

    // Invalid decode slots enter as a clean bubble; writes to x0 are
    // dropped here so no later stage ever advertises a write to x0.
    always_comb begin
        tag_decode = TAG_BUBBLE;
        if (valid_decode) begin
            tag_decode.valid         = 1'b1;
            tag_decode.rs1Addr       = rs1Addr_decode;
            tag_decode.rs2Addr       = rs2Addr_decode;
            tag_decode.rdAddr        = rdAddr_decode;
            tag_decode.rdWriteEnable = rdWriteEnable_decode
                                     & (rdAddr_decode != 5'd0);
            tag_decode.rdSource      = rdSource_decode;
        end
    end

    jzjpcc_stage_reg #(
        .T      (stage_tag_t),
        .BUBBLE (TAG_BUBBLE)
    ) u_execute (
        .clock (clock),
        .reset (reset),
        .flush (flush_execute),
        .stall (stall_decode),
        .d     (tag_decode),
        .q     (tag_execute)
    );

    // Bubbles carry zero data.
    always_comb begin
        mem_d.tag = to_write_tag(tag_execute);
        mem_d.alu = tag_execute.valid ? aluResult_execute : '0;
    end

    jzjpcc_stage_reg #(
        .T      (mem_slot_t),
        .BUBBLE ('0)
    ) u_memory (
        .clock (clock),
        .reset (reset),
        .flush (1'b0),
        .stall (1'b0),
        .d     (mem_d),
        .q     (mem_q)
    );

    always_comb begin
        wb_d.tag  = mem_q.tag;
        wb_d.alu  = mem_q.alu;
        wb_d.load = mem_q.tag.valid ? loadData_memory : '0;
    end

    jzjpcc_stage_reg #(
        .T      (wb_slot_t),
        .BUBBLE ('0)
    ) u_writeback (
        .clock (clock),
        .reset (reset),
        .flush (1'b0),
        .stall (1'b0),
        .d     (wb_d),
        .q     (wb_q)
    );

    always_comb begin
        retired_d = retired_q + RETIRE_WIDTH'(wb_q.tag.valid);
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    assign rs1Addr_execute         = tag_execute.rs1Addr;
    assign rs2Addr_execute         = tag_execute.rs2Addr;
    assign rdAddr_execute          = tag_execute.rdAddr;
    assign rdWriteEnable_execute   = tag_execute.rdWriteEnable;
    assign rdSource_execute        = tag_execute.rdSource;
    assign rdAddr_memory           = mem_q.tag.rdAddr;
    assign rdWriteEnable_memory    = mem_q.tag.rdWriteEnable;
    assign rdSource_memory         = mem_q.tag.rdSource;
    assign aluResult_memory        = mem_q.alu;
    assign rdAddr_writeback        = wb_q.tag.rdAddr;
    assign rdWriteEnable_writeback = wb_q.tag.rdWriteEnable;
    assign rd_writebackEnd         = wb_q.tag.rdSource ? wb_q.load : wb_q.alu;
    assign retired                 = retired_q;

endmodule

// File: tb/tb_jzjpcc_stage_tag_pipeline.sv
// Scoreboard bench for jzjpcc_stage_tag_pipeline: directed scenarios plus
// randomized traffic against a slot-level reference model; 8-bit retire copy for wrap.
module tb_jzjpcc_stage_tag_pipeline;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs1Addr_decode = '0;
    logic [4:0]  rs2Addr_decode = '0;
    logic [4:0]  rdAddr_decode = '0;
    logic        rdWriteEnable_decode = 1'b0;
    logic        rdSource_decode = 1'b0;
    logic        valid_decode = 1'b0;
    logic        stall_decode = 1'b0;
    logic        flush_execute = 1'b0;
    logic [31:0] aluResult_execute = '0;
    logic [31:0] loadData_memory = '0;

    logic [4:0]  rs1Addr_execute, rs2Addr_execute, rdAddr_execute;
    logic        rdWriteEnable_execute, rdSource_execute;
    logic [4:0]  rdAddr_memory;
    logic        rdWriteEnable_memory, rdSource_memory;
    logic [31:0] aluResult_memory;
    logic [4:0]  rdAddr_writeback;
    logic        rdWriteEnable_writeback;
    logic [31:0] rd_writebackEnd;
    logic [63:0] retired;

    logic [4:0]  rs1e8, rs2e8, rde8, rdm8, rdw8;
    logic        wee8, srce8, wem8, srcm8, wew8;
    logic [31:0] alum8, wbend8;
    logic [7:0]  retired8;

    always #5 clock = ~clock;

    jzjpcc_stage_tag_pipeline dut (
        .clock                   (clock),
        .reset                   (reset),
        .rs1Addr_decode          (rs1Addr_decode),
        .rs2Addr_decode          (rs2Addr_decode),
        .rdAddr_decode           (rdAddr_decode),
        .rdWriteEnable_decode    (rdWriteEnable_decode),
        .rdSource_decode         (rdSource_decode),
        .valid_decode            (valid_decode),
        .stall_decode            (stall_decode),
        .flush_execute           (flush_execute),
        .aluResult_execute       (aluResult_execute),
        .loadData_memory         (loadData_memory),
        .rs1Addr_execute         (rs1Addr_execute),
        .rs2Addr_execute         (rs2Addr_execute),
        .rdAddr_execute          (rdAddr_execute),
        .rdWriteEnable_execute   (rdWriteEnable_execute),
        .rdSource_execute        (rdSource_execute),
        .rdAddr_memory           (rdAddr_memory),
        .rdWriteEnable_memory    (rdWriteEnable_memory),
        .rdSource_memory         (rdSource_memory),
        .aluResult_memory        (aluResult_memory),
        .rdAddr_writeback        (rdAddr_writeback),
        .rdWriteEnable_writeback (rdWriteEnable_writeback),
        .rd_writebackEnd         (rd_writebackEnd),
        .retired                 (retired)
    );

    jzjpcc_stage_tag_pipeline #(.XLEN(32), .RETIRE_WIDTH(8)) dut8 (
        .clock                   (clock),
        .reset                   (reset),
        .rs1Addr_decode          (rs1Addr_decode),
        .rs2Addr_decode          (rs2Addr_decode),
        .rdAddr_decode           (rdAddr_decode),
        .rdWriteEnable_decode    (rdWriteEnable_decode),
        .rdSource_decode         (rdSource_decode),
        .valid_decode            (valid_decode),
        .stall_decode            (stall_decode),
        .flush_execute           (flush_execute),
        .aluResult_execute       (aluResult_execute),
        .loadData_memory         (loadData_memory),
        .rs1Addr_execute         (rs1e8),
        .rs2Addr_execute         (rs2e8),
        .rdAddr_execute          (rde8),
        .rdWriteEnable_execute   (wee8),
        .rdSource_execute        (srce8),
        .rdAddr_memory           (rdm8),
        .rdWriteEnable_memory    (wem8),
        .rdSource_memory         (srcm8),
        .aluResult_memory        (alum8),
        .rdAddr_writeback        (rdw8),
        .rdWriteEnable_writeback (wew8),
        .rd_writebackEnd         (wbend8),
        .retired                 (retired8)
    );

    // One in-flight instruction as the spec describes it.
    typedef struct {
        bit        v;
        bit [4:0]  rs1, rs2, rd;
        bit        we, src;
        bit [31:0] alu, ld;
    } slot_t;

    // Expected visible outputs just after a clock edge.
    typedef struct {
        bit [4:0]        rs1e, rs2e, rde;
        bit              wee, srce;
        bit [4:0]        rdm;
        bit              wem, srcm;
        bit [31:0]       alum;
        bit [4:0]        rdw;
        bit              wew;
        bit [31:0]       wbend;
        longint unsigned ret;
    } snap_t;

    slot_t           ex_m, mem_m, wb_m;
    longint unsigned ret_m;
    snap_t           exp_q[$];
    snap_t           e;
    int              checks = 0;
    int              errors = 0;

    task automatic chk(input string name, input longint unsigned act,
                       input longint unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic slot_t empty_slot();
        slot_t s;
        s = '{v: 0, rs1: 0, rs2: 0, rd: 0, we: 0, src: 0, alu: 0, ld: 0};
        return s;
    endfunction

    task automatic model_clear();
        ex_m  = empty_slot();
        mem_m = empty_slot();
        wb_m  = empty_slot();
        ret_m = 0;
        exp_q.delete();
    endtask

    // Drive one decode cycle and push what the pipeline must show after
    // the following rising edge.
    task automatic step(input bit v, input bit [4:0] r1, input bit [4:0] r2,
                        input bit [4:0] rd, input bit we, input bit src,
                        input bit stall, input bit flush,
                        input bit [31:0] alu, input bit [31:0] ld);
        snap_t s;
        @(negedge clock);
        valid_decode         = v;
        rs1Addr_decode       = r1;
        rs2Addr_decode       = r2;
        rdAddr_decode        = rd;
        rdWriteEnable_decode = we;
        rdSource_decode      = src;
        stall_decode         = stall;
        flush_execute        = flush;
        aluResult_execute    = alu;
        loadData_memory      = ld;

        if (ex_m.v)  ex_m.alu = alu;
        if (mem_m.v) mem_m.ld = ld;
        if (wb_m.v)  ret_m++;
        wb_m  = mem_m;
        mem_m = ex_m;
        if (flush) begin
            ex_m = empty_slot();
        end else if (!stall) begin
            ex_m = empty_slot();
            if (v) begin
                ex_m.v   = 1;
                ex_m.rs1 = r1;
                ex_m.rs2 = r2;
                ex_m.rd  = rd;
                ex_m.we  = we && (rd != 0);
                ex_m.src = src;
            end
        end

        s.rs1e  = ex_m.rs1;
        s.rs2e  = ex_m.rs2;
        s.rde   = ex_m.rd;
        s.wee   = ex_m.we;
        s.srce  = ex_m.src;
        s.rdm   = mem_m.rd;
        s.wem   = mem_m.we;
        s.srcm  = mem_m.src;
        s.alum  = mem_m.v ? mem_m.alu : 0;
        s.rdw   = wb_m.rd;
        s.wew   = wb_m.we;
        s.wbend = !wb_m.v ? 0 : (wb_m.src ? wb_m.ld : wb_m.alu);
        s.ret   = ret_m;
        exp_q.push_back(s);
    endtask

    task automatic bubble(input int n);
        for (int i = 0; i < n; i++)
            step(0, 5'($urandom), 5'($urandom), 5'($urandom), 1, 1, 0, 0,
                 $urandom, $urandom);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_rs1e"}, rs1Addr_execute, 0);
        chk({tag, "_rde"}, rdAddr_execute, 0);
        chk({tag, "_wee"}, rdWriteEnable_execute, 0);
        chk({tag, "_rdm"}, rdAddr_memory, 0);
        chk({tag, "_alum"}, aluResult_memory, 0);
        chk({tag, "_rdw"}, rdAddr_writeback, 0);
        chk({tag, "_wew"}, rdWriteEnable_writeback, 0);
        chk({tag, "_wbend"}, rd_writebackEnd, 0);
        chk({tag, "_ret"}, retired, 0);
        chk({tag, "_ret8"}, retired8, 0);
    endtask

    // Reset asserted mid low-phase while instructions are in flight.
    task automatic do_reset();
        @(negedge clock);
        #2 reset = 1'b1;
        #1 check_all_zero("rst_async");
        model_clear();
        valid_decode  = 0;
        stall_decode  = 0;
        flush_execute = 0;
        @(posedge clock);
        #1 check_all_zero("rst_hold");
        @(negedge clock);
        reset = 1'b0;
    endtask

    always @(posedge clock) begin
        #1;
        if (!reset && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("rs1_ex", rs1Addr_execute, e.rs1e);
            chk("rs2_ex", rs2Addr_execute, e.rs2e);
            chk("rd_ex", rdAddr_execute, e.rde);
            chk("we_ex", rdWriteEnable_execute, e.wee);
            chk("src_ex", rdSource_execute, e.srce);
            chk("rd_mem", rdAddr_memory, e.rdm);
            chk("we_mem", rdWriteEnable_memory, e.wem);
            chk("src_mem", rdSource_memory, e.srcm);
            chk("alu_mem", aluResult_memory, e.alum);
            chk("rd_wb", rdAddr_writeback, e.rdw);
            chk("we_wb", rdWriteEnable_writeback, e.wew);
            chk("wb_end", rd_writebackEnd, e.wbend);
            chk("retired", retired, e.ret);
            chk("retired8", retired8, e.ret & 64'hff);
        end
    end

    initial begin
        model_clear();
        #1 check_all_zero("por");
        @(negedge clock);
        reset = 1'b0;

        // Straight-line ALU write.
        step(1, 1, 2, 5, 1, 0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h1234, 0);
        bubble(3);

        // Load into x7.
        step(1, 3, 4, 7, 1, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h5555, 0);
        step(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'hDEADBEEF);
        bubble(3);

        // Write to x0 must never advertise a write.
        step(1, 6, 6, 0, 1, 0, 0, 0, 0, 0);
        bubble(4);

        // Flush and stall together with rd=9 waiting in decode.
        step(1, 8, 8, 3, 1, 0, 0, 0, 0, 0);
        step(1, 2, 1, 9, 1, 0, 1, 1, 32'hAAAA0001, 0);
        step(1, 2, 1, 9, 1, 0, 0, 0, 0, 32'hBBBB0002);
        step(0, 0, 0, 0, 0, 0, 0, 0, 32'h00009999, 0);
        bubble(4);

        // Fill the pipe, then reset with stages full.
        for (int i = 0; i < 6; i++)
            step(1, 5'($urandom), 5'($urandom), 5'($urandom_range(1, 31)),
                 1, 1'($urandom), 0, 0, $urandom, $urandom);
        do_reset();

        // Long random stream; enough retirements to wrap the 8-bit counter.
        for (int i = 0; i < 800; i++)
            step($urandom_range(0, 99) < 80,
                 5'($urandom), 5'($urandom), 5'($urandom), 1'($urandom),
                 1'($urandom), $urandom_range(0, 99) < 15,
                 $urandom_range(0, 99) < 8, $urandom, $urandom);
        bubble(4);

        repeat (3) @(posedge clock);
        #2 chk("drain", exp_q.size(), 0);
        chk("wrap_seen", ret_m > 255, 1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
